// File: rtl/pci_target_burst_pkg.sv
// Shared definitions for the burst PCI target: bus command codes, FSM states and byte-lane merge.
package pci_target_burst_pkg;

    typedef enum logic [3:0] {
        CMD_SPECIAL   = 4'b0001,
        CMD_MEM_READ  = 4'b0110,
        CMD_MEM_WRITE = 4'b0111
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_TURN,
        S_RD,
        S_DISC,
        S_SPC,
        S_BUSY
    } state_e;

    // C_BE lanes are active-low: a 0 lets the new byte through.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be_n);
        logic [31:0] r;
        r = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!be_n[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pci_target_burst_if.sv
// Initiator/target control lines of the shared PCI bus; Address_Data stays a plain inout on the target.
interface pci_target_burst_if;
    logic [3:0] C_BE;
    logic       NFRAME;
    logic       NIRED;
    logic       NTRED;
    logic       NDEVSEL;
    logic       stop;

    modport master (output C_BE, NFRAME, NIRED, input NTRED, NDEVSEL, stop);
    modport slave  (input C_BE, NFRAME, NIRED, output NTRED, NDEVSEL, stop);
endinterface

// File: rtl/pci_target_burst_msg_fifo.sv
// Special-cycle message FIFO; a push while full is accepted only when a pop frees a slot the same cycle.
module pci_msg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pci_target_burst.sv
// PCI target with a linear-burst word buffer, disconnect at buffer end and special-cycle capture.
module pci_target_burst
    import pci_target_burst_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned MSG_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [31:0]       Address_Data,
    pci_target_burst_if.slave pci,
    output logic [31:0]       msg_data,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic [CNT_W-1:0]  msg_drop_cnt
);
    localparam int unsigned   AW   = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(MEM_DEPTH - 1);

    state_e        state;
    state_e        state_nx;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_inc;
    logic [31:0]   rdata;
    logic [31:0]   mem [MEM_DEPTH];
    logic          xfer, abort, hit, wr_en;
    logic          ntred, ndevsel, stop_n;
    logic          push, pop, drop, fifo_full, fifo_empty;

    assign xfer     = !pci.NIRED && (state == S_WR || state == S_RD);
    assign abort    = pci.NFRAME && pci.NIRED;
    assign hit      = (Address_Data[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign addr_inc = addr + AW'(1);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ntred    = 1'b1;
        ndevsel  = 1'b1;
        stop_n   = 1'b1;
        wr_en    = 1'b0;
        unique case (state)
            S_IDLE: if (!pci.NFRAME) begin
                if (hit && pci.C_BE == CMD_MEM_WRITE)     state_nx = S_WR;
                else if (hit && pci.C_BE == CMD_MEM_READ) state_nx = S_TURN;
                else if (pci.C_BE == CMD_SPECIAL)         state_nx = S_SPC;
                else                                      state_nx = S_BUSY;
            end
            S_WR, S_RD: begin
                ntred   = 1'b0;
                ndevsel = 1'b0;
                wr_en   = xfer && (state == S_WR);
                if (abort) state_nx = S_IDLE;
                else if (xfer) begin
                    if (pci.NFRAME)        state_nx = S_IDLE;
                    else if (addr == LAST) state_nx = S_DISC;
                end
            end
            S_TURN: begin
                ndevsel  = 1'b0;
                state_nx = abort ? S_IDLE : S_RD;
            end
            S_DISC: begin
                ndevsel = 1'b0;
                stop_n  = 1'b0;
                if (abort) state_nx = S_IDLE;
            end
            S_SPC:   if (!pci.NIRED) state_nx = S_IDLE;
            S_BUSY:  if (abort) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign pci.NTRED   = ntred;
    assign pci.NDEVSEL = ndevsel;
    assign pci.stop    = stop_n;
    assign Address_Data = (state == S_RD) ? rdata : 'z;

    // rdata is prefetched one word ahead so back-to-back reads need no wait state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr         <= '0;
            rdata        <= '0;
            msg_drop_cnt <= '0;
        end else begin
            if (state == S_IDLE && !pci.NFRAME) addr <= Address_Data[AW+1:2];
            else if (xfer)                      addr <= addr_inc;
            if (state == S_TURN)               rdata <= mem[addr];
            else if (state == S_RD && xfer)    rdata <= mem[addr_inc];
            if (drop && msg_drop_cnt != '1)    msg_drop_cnt <= msg_drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[addr] <= be_merge(mem[addr], Address_Data, pci.C_BE);
    end

    assign push      = (state == S_SPC) && !pci.NIRED;
    assign pop       = msg_valid && msg_ready;
    assign drop      = push && fifo_full && !pop;
    assign msg_valid = !fifo_empty;

    pci_msg_fifo #(
        .DEPTH (MSG_DEPTH),
        .WIDTH (32)
    ) u_msg_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (Address_Data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (msg_data)
    );

endmodule

// File: tb/tb_pci_target_burst.sv
// Bench for pci_target_burst: directed corner sequences, a byte-enable table and random traffic against a model.
module tb_pci_target_burst;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MSGD  = 4;

    typedef struct {
        int unsigned word;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ad_drv = '0;
    logic        ad_oe = 1'b0;
    wire  [31:0] ad;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic [7:0]  msg_drop_cnt;

    pci_target_burst_if bus();
    assign ad = ad_oe ? ad_drv : 'z;

    pci_target_burst #(
        .BASE_ADDR (BASE),
        .MEM_DEPTH (DEPTH),
        .MSG_DEPTH (MSGD),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Address_Data (ad),
        .pci          (bus),
        .msg_data     (msg_data),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_drop_cnt (msg_drop_cnt)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] mq [$];
    int unsigned drop_m = 0;
    bit          cap_now = 0;
    logic [31:0] cap_word = '0;
    bit          rand_ready = 0;
    logic [31:0] buf_d  [DEPTH];
    logic [3:0]  buf_be [DEPTH];
    logic [31:0] rd_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{~be[3]}}, {8{~be[2]}}, {8{~be[1]}}, {8{~be[0]}}};
        return (d & mask) | (old & ~mask);
    endfunction

    // One clock: advance the message model using pre-edge inputs, then check the message outputs.
    task automatic tick();
        bit do_pop;
        do_pop = msg_ready && (mq.size() != 0);
        if (!reset) begin
            mq.delete();
            drop_m = 0;
        end else begin
            if (cap_now) begin
                if (mq.size() < MSGD || do_pop) mq.push_back(cap_word);
                else if (drop_m < 255) drop_m++;
            end
            if (do_pop) void'(mq.pop_front());
        end
        cap_now = 0;
        @(posedge clk);
        #1;
        if (rand_ready) msg_ready = 1'($urandom_range(0, 1));
        check("msg_valid", 32'(msg_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("msg_data", msg_data, mq[0]);
        check("msg_drop_cnt", 32'(msg_drop_cnt), drop_m);
    endtask

    task automatic end_bus();
        bus.NFRAME = 1'b1;
        bus.NIRED  = 1'b1;
        bus.C_BE   = 4'b0000;
        ad_oe      = 1'b0;
        check("release_ndevsel", 32'(bus.NDEVSEL), 32'd1);
        check("release_ntred", 32'(bus.NTRED), 32'd1);
        check("release_stop", 32'(bus.stop), 32'd1);
        tick();
    endtask

    task automatic bus_write(input int unsigned start, input int unsigned n);
        ad_oe = 1'b1; ad_drv = BASE + 32'(start * 4);
        bus.C_BE = 4'b0111; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        for (int unsigned i = 0; i < n; i++) begin
            ad_drv = buf_d[i]; bus.C_BE = buf_be[i];
            bus.NIRED = 1'b0; bus.NFRAME = (i == n - 1);
            check("wr_ntred", 32'(bus.NTRED), 32'd0);
            check("wr_ndevsel", 32'(bus.NDEVSEL), 32'd0);
            mem_m[start + i] = apply_be(mem_m[start + i], buf_d[i], buf_be[i]);
            tick();
        end
        end_bus();
    endtask

    task automatic bus_read(input int unsigned start, input int unsigned n);
        int unsigned b;
        ad_oe = 1'b1; ad_drv = BASE + 32'(start * 4);
        bus.C_BE = 4'b0110; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        ad_oe = 1'b0; bus.C_BE = 4'b0000; bus.NIRED = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            bus.NFRAME = (i == n - 1);
            b = 0;
            while (bus.NTRED !== 1'b0 && b < 8) begin
                tick();
                b++;
            end
            check("rd_ntred", 32'(bus.NTRED), 32'd0);
            #1;
            rd_last = ad;
            check("rd_data", ad, mem_m[start + i]);
            tick();
        end
        end_bus();
    endtask

    task automatic special(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        ad_oe = 1'b1; ad_drv = a;
        bus.C_BE = 4'b0001; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        ad_drv = d; bus.C_BE = 4'b0000; bus.NFRAME = 1'b1; bus.NIRED = 1'b0;
        if (!rand_ready) msg_ready = rdy;
        cap_now = 1; cap_word = d;
        check("spc_ndevsel", 32'(bus.NDEVSEL), 32'd1);
        check("spc_ntred", 32'(bus.NTRED), 32'd1);
        tick();
        if (!rand_ready) msg_ready = 1'b0;
        end_bus();
    endtask

    task automatic miss(input bit other_cmd);
        ad_oe = 1'b1;
        ad_drv = other_cmd ? BASE : 32'h0000_2000 + 32'($urandom_range(0, 15) * 4);
        bus.C_BE = other_cmd ? 4'b0010 : 4'b0111; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        ad_drv = $urandom; bus.C_BE = 4'b0000; bus.NIRED = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            bus.NFRAME = (i == 2);
            check("miss_ndevsel", 32'(bus.NDEVSEL), 32'd1);
            check("miss_ntred", 32'(bus.NTRED), 32'd1);
            tick();
        end
        end_bus();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [6];
        int unsigned kind, s, n, lim;

        vt[0] = '{5,  32'hAABBCCDD, 4'b1010, 32'h00BB00DD};
        vt[1] = '{9,  32'h12345678, 4'b0000, 32'h12345678};
        vt[2] = '{10, 32'hFFFFFFFF, 4'b1110, 32'h000000FF};
        vt[3] = '{11, 32'hCAFEBABE, 4'b1111, 32'h00000000};
        vt[4] = '{5,  32'h11223344, 4'b0101, 32'h11BB33DD};
        vt[5] = '{9,  32'h0000FFFF, 4'b0011, 32'h00005678};

        bus.NFRAME = 1'b1; bus.NIRED = 1'b1; bus.C_BE = 4'b0000;
        reset = 1'b0;
        tick();
        tick();
        check("reset_ntred", 32'(bus.NTRED), 32'd1);
        check("reset_ndevsel", 32'(bus.NDEVSEL), 32'd1);
        check("reset_stop", 32'(bus.stop), 32'd1);
        reset = 1'b1;
        tick();

        // Full-window burst ending on the last word with NFRAME high: a normal end, no stop.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_d[i] = '0; buf_be[i] = 4'b0000;
        end
        bus_write(0, DEPTH);

        buf_d[0] = 32'h11111111; buf_d[1] = 32'h22222222; buf_d[2] = 32'h33333333;
        buf_be[0] = 4'b0000; buf_be[1] = 4'b0000; buf_be[2] = 4'b0000;
        bus_write(0, 3);
        bus_read(0, 3);

        for (int unsigned i = 0; i < 6; i++) begin
            buf_d[0] = vt[i].data; buf_be[0] = vt[i].be;
            bus_write(vt[i].word, 1);
            bus_read(vt[i].word, 1);
            check("be_vector", rd_last, vt[i].exp);
        end

        // Read at 0x1004: claim on edge 1, first data on edge 2, then zero-wait.
        ad_oe = 1'b1; ad_drv = 32'h0000_1004;
        bus.C_BE = 4'b0110; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        ad_oe = 1'b0; bus.NIRED = 1'b0;
        check("turn_ndevsel", 32'(bus.NDEVSEL), 32'd0);
        check("turn_ntred", 32'(bus.NTRED), 32'd1);
        tick();
        #1;
        check("rd1_ntred", 32'(bus.NTRED), 32'd0);
        check("rd1_data", ad, 32'h22222222);
        tick();
        #1;
        check("rd2_data", ad, 32'h33333333);
        bus.NFRAME = 1'b1;
        tick();
        end_bus();

        // Disconnect: burst from word 14 keeps NFRAME low past the buffer end.
        ad_oe = 1'b1; ad_drv = BASE + 32'd56;
        bus.C_BE = 4'b0111; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        ad_drv = 32'hE0E0E0E0; bus.C_BE = 4'b0000; bus.NIRED = 1'b0;
        mem_m[14] = 32'hE0E0E0E0;
        tick();
        ad_drv = 32'hF0F0F0F0;
        mem_m[15] = 32'hF0F0F0F0;
        tick();
        ad_drv = 32'h0BADBEEF;
        check("disc_stop", 32'(bus.stop), 32'd0);
        check("disc_ntred", 32'(bus.NTRED), 32'd1);
        check("disc_ndevsel", 32'(bus.NDEVSEL), 32'd0);
        tick();
        check("disc_hold_stop", 32'(bus.stop), 32'd0);
        bus.NFRAME = 1'b1;
        tick();
        check("disc_hold2_stop", 32'(bus.stop), 32'd0);
        bus.NIRED = 1'b1;
        tick();
        check("disc_exit_stop", 32'(bus.stop), 32'd1);
        check("disc_exit_ndevsel", 32'(bus.NDEVSEL), 32'd1);
        bus_read(14, 2);
        bus_read(0, 1);

        miss(0);
        miss(1);

        // Special cycles: five with no pop overflow a 4-deep FIFO by one.
        special(32'h11111111, 32'h00000000, 1'b0);
        check("spc_first_valid", 32'(msg_valid), 32'd1);
        check("spc_first_data", msg_data, 32'h00000000);
        for (int unsigned i = 1; i < 5; i++) special(32'h11111111, 32'hA0000000 + 32'(i), 1'b0);
        check("spc_drop_one", 32'(msg_drop_cnt), 32'd1);
        special(32'h11111111, 32'hB0000005, 1'b1);
        check("spc_full_pop_drop", 32'(msg_drop_cnt), 32'd1);

        // Reset mid-burst: first word kept, the word under reset is not written, FIFO and drop count cleared.
        ad_oe = 1'b1; ad_drv = BASE + 32'd12;
        bus.C_BE = 4'b0111; bus.NFRAME = 1'b0; bus.NIRED = 1'b1;
        tick();
        ad_drv = 32'h5A5A5A5A; bus.C_BE = 4'b0000; bus.NIRED = 1'b0;
        mem_m[3] = 32'h5A5A5A5A;
        tick();
        ad_drv = 32'hC3C3C3C3; reset = 1'b0;
        tick();
        check("rstmid_ntred", 32'(bus.NTRED), 32'd1);
        check("rstmid_ndevsel", 32'(bus.NDEVSEL), 32'd1);
        check("rstmid_stop", 32'(bus.stop), 32'd1);
        tick();
        check("rstmid_valid", 32'(msg_valid), 32'd0);
        check("rstmid_drop", 32'(msg_drop_cnt), 32'd0);
        reset = 1'b1; bus.NFRAME = 1'b1; bus.NIRED = 1'b1; ad_oe = 1'b0;
        tick();
        bus_read(3, 2);

        rand_ready = 1;
        for (int unsigned t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 3);
            s    = $urandom_range(0, DEPTH - 1);
            lim  = (DEPTH - s < 4) ? DEPTH - s : 4;
            n    = $urandom_range(1, lim);
            case (kind)
                0: begin
                    for (int unsigned i = 0; i < n; i++) begin
                        buf_d[i]  = $urandom;
                        buf_be[i] = 4'($urandom_range(0, 15));
                    end
                    bus_write(s, n);
                end
                1: bus_read(s, n);
                2: special($urandom, $urandom, 1'b0);
                default: miss(1'($urandom_range(0, 1)));
            endcase
        end
        rand_ready = 0;
        msg_ready  = 1'b1;
        repeat (8) tick();
        for (int unsigned w = 0; w < DEPTH; w += 4) bus_read(w, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
